// File: rtl/soc_pio_in_pkg.sv
// Shared constants for the parametrised input-capture PIO: register word
// addresses and the Avalon data-bus width.
package soc_pio_in_pkg;

  localparam int PIO_DATA_W = 32;

  localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
  localparam logic [2:0] PIO_ADDR_RISE    = 3'd1;
  localparam logic [2:0] PIO_ADDR_FALL    = 3'd2;
  localparam logic [2:0] PIO_ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] PIO_ADDR_MASK    = 3'd4;

endpackage

// File: rtl/soc_pio_in_debounce.sv
// One-bit debounce filter: the output follows the synchronised input only
// after it has disagreed with the output for DEBOUNCE_CYCLES consecutive cycles.
module soc_pio_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The edge that would take the count to DEBOUNCE_CYCLES commits the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soc_system_pio_in_capture.sv
// Avalon-MM input PIO with per-bit rise/fall edge capture and masked irq.
// Optional per-bit debounce filter compiled in by SOC_PIO_IN_DEBOUNCE_EN.
module soc_system_pio_in_capture
  import soc_pio_in_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [PIO_DATA_W-1:0] writedata,
  output logic [PIO_DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  if (WIDTH < 1 || WIDTH > PIO_DATA_W) begin : g_bad_width
    $error("WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be 2..65535");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_strobe;
  logic [PIO_DATA_W-1:0] rd_next;

  // Synchroniser stage: in_port is fully asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef SOC_PIO_IN_DEBOUNCE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
    soc_pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (sync_out[gi]),
      .dout   (filt[gi])
    );
  end
`else
  assign filt = sync_out;
`endif

  // Edge-detect stage: history flop and per-bit direction enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) filt_d <= '0;
    else          filt_d <= filt;
  end

  assign rise     = filt & ~filt_d;
  assign fall     = ~filt & filt_d;
  assign edge_hit = (rise & rise_en) | (fall & fall_en);

  assign wr_strobe = chipselect & ~write_n;
  assign wdata     = writedata[WIDTH-1:0];
  assign cap_clr   = (wr_strobe && address == PIO_ADDR_CAPTURE) ? wdata : '0;

  if (WIDTH < PIO_DATA_W) begin : g_wd_hi
    logic unused_wd_hi;
    assign unused_wd_hi = ^writedata[PIO_DATA_W-1:WIDTH];
  end

  // Register stage: a same-cycle edge overrides its own clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en  <= '0;
      fall_en  <= '0;
      irq_mask <= '0;
      capture  <= '0;
    end else begin
      capture <= (capture & ~cap_clr) | edge_hit;
      if (wr_strobe) begin
        case (address)
          PIO_ADDR_RISE: rise_en  <= wdata;
          PIO_ADDR_FALL: fall_en  <= wdata;
          PIO_ADDR_MASK: irq_mask <= wdata;
          default: ;
        endcase
      end
    end
  end

  // Address is decoded every cycle, independent of chipselect.
  always_comb begin
    rd_next = '0;
    case (address)
      PIO_ADDR_DATA:    rd_next[WIDTH-1:0] = filt;
      PIO_ADDR_RISE:    rd_next[WIDTH-1:0] = rise_en;
      PIO_ADDR_FALL:    rd_next[WIDTH-1:0] = fall_en;
      PIO_ADDR_CAPTURE: rd_next[WIDTH-1:0] = capture;
      PIO_ADDR_MASK:    rd_next[WIDTH-1:0] = irq_mask;
      default:          rd_next = '0;
    endcase
  end

  // Output stage: registered read data and interrupt level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_next;
      irq      <= |(capture & irq_mask);
    end
  end

endmodule
